// File: rtl/ssd_pkg.sv
// Shared types, constants and the segment encoder for the seven-segment display driver.
package ssd_pkg;

  localparam int BCD_W = 16;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles cannot occur and go dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 13-bit binary to four BCD digits in 13 shift cycles.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [12:0]       bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output conv_state_e       state
);

  // Handshake: start is accepted only while busy is low (IDLE); bin is captured
  // on that edge, and bcd holds the result from the edge that leaves DONE.
  conv_state_e       state_q, state_d;
  logic [28:0]       sr_q, sr_d, adj;
  logic [3:0]        iter_q, iter_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  always_comb begin
    adj = sr_q;
    for (int k = 0; k < 4; k++) begin
      if (sr_q[13 + 4*k +: 4] >= 4'd5) adj[13 + 4*k +: 4] = sr_q[13 + 4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {16'b0, bin};
          iter_d  = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = {adj[27:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd12) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = sr_q[28:13];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign bcd   = bcd_q;
  assign state = state_q;

endmodule

// File: rtl/ssd_display_driver.sv
// Converts the debug word to BCD and time-multiplexes it onto a 4-digit common-anode display.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [12:0]       value,
  output logic [3:0]        anode,
  output logic [6:0]        cathode,
  output logic [BCD_W-1:0]  bcd,
  output logic              busy
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [12:0]      src_q;
  logic             pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;

  conv_state_e      conv_state;
  logic             conv_busy, conv_done_unused, conv_start;
  logic [BCD_W-1:0] conv_bcd;
  logic [3:0]       nib;
  logic             blank;

  // pending forces one conversion after reset even when value equals the reset src.
  assign conv_start = (conv_state == ST_IDLE) && (pending_q || (value != src_q));

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done_unused),
    .bcd   (conv_bcd),
    .state (conv_state)
  );

  always_comb begin
    nib   = conv_bcd[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: nib = conv_bcd[3:0];
      2'd1: begin
        nib   = conv_bcd[7:4];
        blank = BLANK_LZ && (conv_bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = conv_bcd[11:8];
        blank = BLANK_LZ && (conv_bcd[15:8] == 8'd0);
      end
      default: begin
        nib   = conv_bcd[15:12];
        blank = BLANK_LZ && (conv_bcd[15:12] == 4'd0);
      end
    endcase
    anode_d   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    cathode_d = blank ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      pending_q <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      anode_q   <= 4'b1111;
      cathode_q <= SEG_BLANK;
    end else begin
      if (conv_start) begin
        src_q     <= value;
        pending_q <= 1'b0;
      end
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign bcd     = conv_bcd;
  assign busy    = conv_busy;

endmodule
